// File: rtl/rr_onehot_arbiter_if.sv
// Requester-bank <-> arbiter bundle: request vector and done pulse in,
// one-hot grant, binary grant index, valid and timeout pulse out.
interface rr_onehot_arbiter_if #(
  parameter int N   = 16,
  parameter int IDW = 4
);
  logic [N-1:0]   req;
  logic           done;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_valid;
  logic           timeout;

  modport master (
    output req, done,
    input  gnt, gnt_id, gnt_valid, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_id, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter: one registered grant at a time, held until done,
// owner withdrawal or hold timeout, with an idle bubble between owners.
module rr_onehot_arbiter #(
  parameter int N   = 16,
  parameter int IDW = 4,
  parameter int TMO = 64,
  parameter int CW  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_onehot_arbiter_if.slave  bus,
  output logic [0:0]          dbg_state,
  output logic [IDW-1:0]      dbg_ptr
);

  // Handshake: req[i] is a level that stays high for as long as requester i
  // wants the resource; a grant is owned while gnt_valid=1 and ends when the
  // owner pulses done for one cycle, drops req[gnt_id], or the hold timer
  // expires. Non-owner requests are ignored while a grant is held.

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]     state;
  logic [IDW-1:0] ptr;
  logic [CW-1:0]  cnt;

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IDW:0]   sum;
  logic [IDW-1:0] win;
  logic           found;
  logic [N-1:0]   win_onehot;
  logic           any_req;
  logic           owner_req;
  logic           tmo_hit;
  logic           release_now;

  // Rotate requests so bit 0 corresponds to ptr; first set bit is the offset.
  always_comb begin
    dbl   = {bus.req, bus.req} >> ptr;
    rot   = dbl[N-1:0];
    sum   = '0;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IDW+1)'(i);
        if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
        win   = sum[IDW-1:0];
      end
    end
  end

  assign win_onehot  = {{(N-1){1'b0}}, 1'b1} << win;
  assign any_req     = |bus.req;
  assign owner_req   = |(bus.req & bus.gnt);
  assign tmo_hit     = (TMO != 0) && (cnt == CW'(TMO - 1));
  assign release_now = bus.done || !owner_req || tmo_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      cnt           <= '0;
      bus.gnt       <= '0;
      bus.gnt_id    <= '0;
      bus.gnt_valid <= 1'b0;
      bus.timeout   <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            bus.gnt       <= win_onehot;
            bus.gnt_id    <= win;
            bus.gnt_valid <= 1'b1;
            ptr           <= (win == IDW'(N - 1)) ? '0 : win + 1'b1;
            cnt           <= '0;
            state         <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (release_now) begin
            bus.gnt       <= '0;
            bus.gnt_id    <= '0;
            bus.gnt_valid <= 1'b0;
            cnt           <= '0;
            state         <= IDLE;
            // Done or withdrawal on the expiry edge is a normal release.
            bus.timeout   <= tmo_hit && !bus.done && owner_req;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;
  assign dbg_ptr   = ptr;

endmodule
